// File: rtl/ascon_round_ctrl.sv
`timescale 1ns/1ps
// Round sequencer for the iterative Ascon permutation: runs p^A or p^B, one round
// per clock, driving the round index and the state-register load/enable controls.
module ascon_round_ctrl #(
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       rounds_sel_i,
    input  logic       abort_i,
    output logic [3:0] round_o,
    output logic       state_load_o,
    output logic       state_en_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned LAST_IDX = 11;
    // Runs always end on index 11, so shorter permutations start later in the schedule.
    localparam logic [CNT_W-1:0] START_A = CNT_W'(12 - ROUNDS_A);
    localparam logic [CNT_W-1:0] START_B = CNT_W'(12 - ROUNDS_B);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_first;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_first_nxt;
    logic [CNT_W-1:0]   w_start_idx;
    logic               w_run_nxt;

    assign w_start_idx = rounds_sel_i ? START_B : START_A;

    // Next-state and counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_first_nxt = r_first;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = w_start_idx;
                    w_first_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_first_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                w_first_nxt = 1'b0;
                if (abort_i) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(LAST_IDX)) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt > CNT_W'(LAST_IDX)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_first_nxt = 1'b0;
            end
        endcase
    end

    assign w_run_nxt = (w_state_nxt == ST_RUN);

    // Outputs are registered from the next-state values so they track the FSM state exactly.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_first      <= 1'b0;
            round_o      <= '0;
            state_load_o <= 1'b0;
            state_en_o   <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_first      <= w_first_nxt;
            round_o      <= w_run_nxt ? w_cnt_nxt : '0;
            state_load_o <= w_run_nxt & w_first_nxt;
            state_en_o   <= w_run_nxt;
            busy_o       <= w_run_nxt;
            done_o       <= (w_state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_ascon_round_ctrl.sv
`timescale 1ns/1ps
// Directed bench for ascon_round_ctrl: table of per-edge vectors plus hand sequences
// for asynchronous reset and a ROUNDS_B=8 instance.
module tb_ascon_round_ctrl;

    typedef struct {
        logic       start;
        logic       sel;
        logic       abort;
        logic [7:0] exp;   // {round[3:0], load, en, busy, done}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, sel = 1'b0, abort = 1'b0;
    logic       start2 = 1'b0, sel2 = 1'b0, abort2 = 1'b0;
    logic [3:0] round, round2;
    logic       load, en, busy, done;
    logic       load2, en2, busy2, done2;

    int n_cmp = 0;
    int n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ascon_round_ctrl u_dut (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start), .rounds_sel_i(sel),
        .abort_i(abort), .round_o(round), .state_load_o(load), .state_en_o(en),
        .busy_o(busy), .done_o(done)
    );

    ascon_round_ctrl #(.ROUNDS_A(12), .ROUNDS_B(8)) u_dut_b8 (
        .clock_i(clk), .resetb_i(rst_n), .start_i(start2), .rounds_sel_i(sel2),
        .abort_i(abort2), .round_o(round2), .state_load_o(load2), .state_en_o(en2),
        .busy_o(busy2), .done_o(done2)
    );

    function automatic logic [7:0] pk(input logic [3:0] r, input logic l, input logic e,
                                      input logic b, input logic d);
        return {r, l, e, b, d};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {round,load,en,busy,done}=%h required %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic m, input logic a, input logic [3:0] r,
                       input logic l, input logic e, input logic b, input logic d);
        vec_t v;
        v.start = s; v.sel = m; v.abort = a; v.exp = pk(r, l, e, b, d);
        vecs.push_back(v);
    endtask

    task automatic add_idle(input logic s, input logic a);
        add(s, 1'b0, a, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_done(input logic s, input logic m);
        add(s, m, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // Reset and idle
        for (int i = 0; i < 5; i++) add_idle(1'b0, 1'b0);
        // p^A: rounds 0..11, done, idle
        add(1, 0, 0, 4'd0, 1, 1, 1, 0);
        for (int r = 1; r <= 11; r++) add(0, 0, 0, 4'(r), 0, 1, 1, 0);
        add_done(0, 0);
        add_idle(0, 0);
        // p^B: rounds 6..11; sel changes during RUN have no effect
        add(1, 1, 0, 4'd6, 1, 1, 1, 0);
        for (int r = 7; r <= 11; r++) add(0, 0, 0, 4'(r), 0, 1, 1, 0);
        add_done(0, 0);
        add_idle(0, 0);
        // start held high: back-to-back p^B with period 7, starts in RUN ignored
        for (int rep = 0; rep < 2; rep++) begin
            add(1, 1, 0, 4'd6, 1, 1, 1, 0);
            for (int r = 7; r <= 11; r++) add(1, 0, 0, 4'(r), 0, 1, 1, 0);
            add_done(1, 1);
        end
        add_idle(0, 0);
        // abort at round 4 of p^A, then abort ignored in IDLE, start beats abort
        add(1, 0, 0, 4'd0, 1, 1, 1, 0);
        for (int r = 1; r <= 4; r++) add(0, 0, 0, 4'(r), 0, 1, 1, 0);
        add_idle(0, 1);
        add_idle(0, 1);
        add_idle(0, 0);
        add(1, 0, 1, 4'd0, 1, 1, 1, 0);
        for (int r = 1; r <= 11; r++) add(0, 0, 0, 4'(r), 0, 1, 1, 0);
        add_done(0, 0);
        // start with abort in DONE: accepted back-to-back
        add(1, 1, 1, 4'd6, 1, 1, 1, 0);
        for (int r = 7; r <= 11; r++) add(0, 1, 0, 4'(r), 0, 1, 1, 0);
        // abort in the round-11 cycle beats DONE
        add_idle(0, 1);
        add_idle(0, 0);
        add_idle(0, 0);

        rst_n = 1'b0;
        #12;
        chk("reset_outputs", pk(round, load, en, busy, done), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start = vecs[i].start;
            sel   = vecs[i].sel;
            abort = vecs[i].abort;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), pk(round, load, en, busy, done), vecs[i].exp);
        end

        // Asynchronous reset while round 9 of p^A is active
        @(negedge clk);
        start = 1'b1; sel = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_seq_r0", pk(round, load, en, busy, done), pk(4'd0, 1, 1, 1, 0));
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_seq_r9", pk(round, load, en, busy, done), pk(4'd9, 0, 1, 1, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_clear", pk(round, load, en, busy, done), 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_post%0d", i), pk(round, load, en, busy, done), 8'h00);
        end
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rst_restart", pk(round, load, en, busy, done), pk(4'd0, 1, 1, 1, 0));
        for (int r = 1; r <= 11; r++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("rst_restart_done", pk(round, load, en, busy, done), pk(4'd0, 0, 0, 0, 1));

        // ROUNDS_B=8 instance: rounds 4..11, done 9 cycles after accepting edge
        @(negedge clk);
        start2 = 1'b1; sel2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] e;
            if (i <= 8) e = pk(4'(3 + i), (i == 1), 1, 1, 0);
            else        e = pk(4'd0, 0, 0, 0, 1);
            chk($sformatf("b8_cyc%0d", i), pk(round2, load2, en2, busy2, done2), e);
            @(posedge clk); #1;
        end
        chk("b8_idle", pk(round2, load2, en2, busy2, done2), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
